// File: rtl/policy_server_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : policy_server_axil_regs
// Brief    : AXI4-Lite slave exposing NUM_REGS read/write policy registers,
//            a read-only committed-write counter and a read-only VERSION word.
// Revision : 1.0 - initial release
// ============================================================================
module policy_server_axil_regs #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] VERSION    = 32'h0003_0001
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  // write response channel
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  // read data channel
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  // register fabric side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int c_strb_w   = DATA_WIDTH / 8;
  localparam int c_addr_lsb = $clog2(c_strb_w);
  localparam int c_idx_w    = ADDR_WIDTH - c_addr_lsb;

  localparam logic [c_idx_w-1:0]    c_cnt_idx = c_idx_w'(NUM_REGS);
  localparam logic [c_idx_w-1:0]    c_ver_idx = c_idx_w'(NUM_REGS + 1);
  localparam logic [DATA_WIDTH-1:0] c_version = DATA_WIDTH'(VERSION);
  localparam logic [1:0]            c_okay    = 2'b00;
  localparam logic [1:0]            c_slverr  = 2'b10;

  // Elaboration-time guard on the supported parameter space
  generate
    if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_data_width
      $error("policy_server_axil_regs: DATA_WIDTH must be 32 or 64");
    end
    if ((NUM_REGS < 1) || (NUM_REGS > ((1 << c_idx_w) - 2))) begin : g_bad_num_regs
      $error("policy_server_axil_regs: NUM_REGS out of range for ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    WS_IDLE    = 2'd0,
    WS_HAVE_AW = 2'd1,
    WS_HAVE_W  = 2'd2,
    WS_RESP    = 2'd3
  } wstate_t;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_RESP = 1'b1
  } rstate_t;

  wstate_t                r_wstate;
  wstate_t                w_wstate_nxt;
  rstate_t                r_rstate;
  rstate_t                w_rstate_nxt;

  logic [c_idx_w-1:0]     r_aw_idx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [c_strb_w-1:0]    r_wstrb;
  logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]  r_wr_count;
  logic [NUM_REGS-1:0]    r_wr_pulse;
  logic [1:0]             r_bresp;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [1:0]             r_rresp;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic                   w_commit;
  logic [c_idx_w-1:0]     w_aw_idx;
  logic [c_idx_w-1:0]     w_ar_idx;
  logic [c_idx_w-1:0]     w_wr_idx;
  logic [DATA_WIDTH-1:0]  w_wr_data;
  logic [c_strb_w-1:0]    w_wr_strb;
  logic                   w_wr_ok;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_rd_ok;
  logic                   w_unused_bits;

  // Byte-offset bits and protection attributes carry no meaning here
  assign w_unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[c_addr_lsb-1:0], S_AXI_ARADDR[c_addr_lsb-1:0]};

  assign w_aw_idx = S_AXI_AWADDR[ADDR_WIDTH-1:c_addr_lsb];
  assign w_ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:c_addr_lsb];

  // Readies are forced low while reset is asserted, independent of state
  assign S_AXI_AWREADY = !ARESET && ((r_wstate == WS_IDLE) || (r_wstate == WS_HAVE_W));
  assign S_AXI_WREADY  = !ARESET && ((r_wstate == WS_IDLE) || (r_wstate == WS_HAVE_AW));
  assign S_AXI_ARREADY = !ARESET && (r_rstate == RS_IDLE);

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_BVALID = (r_wstate == WS_RESP);
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = (r_rstate == RS_RESP);
  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RRESP  = r_rresp;
  assign reg_wr_pulse = r_wr_pulse;

  // Commit operands: take whichever half arrives this cycle live, the other from its latch
  assign w_wr_idx  = (r_wstate == WS_HAVE_AW) ? r_aw_idx : w_aw_idx;
  assign w_wr_data = (r_wstate == WS_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
  assign w_wr_strb = (r_wstate == WS_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;
  assign w_wr_ok   = (w_wr_idx < c_cnt_idx);

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wstate <= WS_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state; commit fires when the later of AW/W completes
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      WS_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = WS_RESP;
          w_commit     = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = WS_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = WS_HAVE_W;
        end
      end
      WS_HAVE_AW: begin
        if (w_w_hs) begin
          w_wstate_nxt = WS_RESP;
          w_commit     = 1'b1;
        end
      end
      WS_HAVE_W: begin
        if (w_aw_hs) begin
          w_wstate_nxt = WS_RESP;
          w_commit     = 1'b1;
        end
      end
      WS_RESP: begin
        if (S_AXI_BREADY) w_wstate_nxt = WS_IDLE;
      end
      default: w_wstate_nxt = WS_IDLE;
    endcase
  end

  // Hold the first-arriving half of a write until its partner shows up
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_idx <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_aw_hs) r_aw_idx <= w_aw_idx;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  // Register file, write counter, response code and per-register strobe
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_wr_count <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        if (w_wr_ok) begin
          r_bresp    <= c_okay;
          r_wr_count <= r_wr_count + DATA_WIDTH'(1);
          for (int k = 0; k < NUM_REGS; k++) begin
            if (w_wr_idx == c_idx_w'(k)) begin
              r_wr_pulse[k] <= 1'b1;
              for (int b = 0; b < c_strb_w; b++) begin
                if (w_wr_strb[b]) r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
              end
            end
          end
        end else begin
          r_bresp <= c_slverr;
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rstate <= RS_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      RS_IDLE: if (w_ar_hs)      w_rstate_nxt = RS_RESP;
      RS_RESP: if (S_AXI_RREADY) w_rstate_nxt = RS_IDLE;
      default:                   w_rstate_nxt = RS_IDLE;
    endcase
  end

  // Read mux over current (pre-commit) register, counter and version values
  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b1;
    if (w_ar_idx < c_cnt_idx) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_ar_idx == c_idx_w'(k)) w_rd_data = r_regs[k];
      end
    end else if (w_ar_idx == c_cnt_idx) begin
      w_rd_data = r_wr_count;
    end else if (w_ar_idx == c_ver_idx) begin
      w_rd_data = c_version;
    end else begin
      w_rd_ok = 1'b0;
    end
  end

  // Capture read payload on the AR handshake and hold it until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_ok ? c_okay : c_slverr;
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
      assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_policy_server_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_policy_server_axil_regs
// Brief    : Directed, self-checking bench for policy_server_axil_regs with a
//            transaction-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_policy_server_axil_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [7:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  policy_server_axil_regs dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_regs [16];
  logic [31:0] m_count = '0;
  bit          m_aw_pend = 0, m_w_pend = 0, m_b_pend = 0, m_r_pend = 0;
  logic [7:0]  m_aw_addr = '0;
  logic [31:0] m_w_data = '0;
  logic [3:0]  m_w_strb = '0;
  logic [1:0]  m_b_resp = '0;
  logic [31:0] m_r_data = '0;
  logic [1:0]  m_r_resp = '0;
  logic [15:0] m_pulse = '0;

  function automatic bit exp_awready();
    return !rst && !m_aw_pend && !m_b_pend;
  endfunction
  function automatic bit exp_wready();
    return !rst && !m_w_pend && !m_b_pend;
  endfunction
  function automatic bit exp_arready();
    return !rst && !m_r_pend;
  endfunction

  function automatic logic [511:0] model_reg_out();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = m_regs[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_count = '0; m_aw_pend = 0; m_w_pend = 0; m_b_pend = 0; m_r_pend = 0;
    m_pulse = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
      end else begin
        bit aw_hs, w_hs, ar_hs;
        int widx, ridx;
        aw_hs = awvalid && exp_awready();
        w_hs  = wvalid && exp_wready();
        ar_hs = arvalid && exp_arready();
        m_pulse = '0;
        if (m_r_pend && rready) m_r_pend = 0;
        if (ar_hs) begin
          ridx = int'(araddr[7:2]);
          m_r_pend = 1;
          m_r_resp = OKAY;
          if (ridx < 16)       m_r_data = m_regs[ridx];
          else if (ridx == 16) m_r_data = m_count;
          else if (ridx == 17) m_r_data = 32'h0003_0001;
          else begin m_r_data = '0; m_r_resp = SLVERR; end
        end
        if (m_b_pend && bready) m_b_pend = 0;
        if (aw_hs) begin m_aw_pend = 1; m_aw_addr = awaddr; end
        if (w_hs) begin m_w_pend = 1; m_w_data = wdata; m_w_strb = wstrb; end
        if (m_aw_pend && m_w_pend) begin
          widx = int'(m_aw_addr[7:2]);
          m_aw_pend = 0; m_w_pend = 0; m_b_pend = 1;
          if (widx < 16) begin
            for (int b = 0; b < 4; b++)
              if (m_w_strb[b]) m_regs[widx][b*8 +: 8] = m_w_data[b*8 +: 8];
            m_count = m_count + 32'd1;
            m_pulse[widx] = 1'b1;
            m_b_resp = OKAY;
          end else begin
            m_b_resp = SLVERR;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("awready", awready, exp_awready());
      chk("wready", wready, exp_wready());
      chk("arready", arready, exp_arready());
      chk("bvalid", bvalid, m_b_pend);
      if (m_b_pend) chk("bresp", bresp, m_b_resp);
      chk("rvalid", rvalid, m_r_pend);
      if (m_r_pend) begin
        chk("rdata", rdata, m_r_data);
        chk("rresp", rresp, m_r_resp);
      end
      chk("reg_wr_pulse", reg_wr_pulse, m_pulse);
      chk("reg_out", reg_out, model_reg_out());
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int bdelay, input logic [1:0] exp_resp,
                          output logic [15:0] pulse);
    bit aw_done = 0, w_done = 0;
    int t = 0;
    pulse = '0;
    @(posedge clk); #1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    if (w_lead == 0) begin awaddr = a; awvalid = 1'b1; end
    while (!(aw_done && w_done) && t < 50) begin
      @(posedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      t++;
      #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      if (!aw_done && t >= w_lead) begin awaddr = a; awvalid = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 1'b0, 1'b1);
    chk("bvalid_after_last_hs", bvalid, 1'b1);
    chk("bresp_lit", bresp, exp_resp);
    pulse = reg_wr_pulse;
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("awready_hold", awready, 1'b0);
      chk("wready_hold", wready, 1'b0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int rdelay);
    bit done = 0;
    int t = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    while (!done && t < 50) begin
      @(posedge clk);
      if (arready) done = 1;
      t++;
      #1;
    end
    arvalid = 1'b0;
    if (!done) chk("read_handshake_timeout", 1'b0, 1'b1);
    chk("rvalid_lit", rvalid, 1'b1);
    chk("rdata_lit", rdata, exp_data);
    chk("rresp_lit", rresp, exp_resp);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, exp_data);
      chk("arready_hold", arready, 1'b0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [15:0] p, p2;
    #1 rst = 1'b1;
    #2;
    chk("reset_awready", awready, 1'b0);
    chk("reset_arready", arready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_awready", awready, 1'b1);
    chk("post_reset_wready", wready, 1'b1);
    chk("post_reset_arready", arready, 1'b1);
    chk("post_reset_regs", reg_out, '0);

    // basic write / read-back
    for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, OKAY, p);
    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 32'(i + 1), OKAY, 0);
    do_read(8'h40, 32'd4, OKAY, 0);
    do_read(8'h44, 32'h0003_0001, OKAY, 0);

    // byte-lane write and strobe
    do_write(8'h00, 32'hAABB_CCDD, 4'b0010, 0, 0, OKAY, p);
    chk("pulse_reg0", p, 16'h0001);
    do_read(8'h00, 32'h0000_CC01, OKAY, 0);
    arprot = 3'b111;
    do_read(8'h03, 32'h0000_CC01, OKAY, 0);
    arprot = 3'b000;

    // W leading AW by 3 cycles, then both in the same cycle
    do_write(8'h10, 32'h1111_1111, 4'hF, 3, 0, OKAY, p);
    chk("pulse_reg4", p, 16'h0010);
    do_write(8'h14, 32'h2222_2222, 4'hF, 0, 0, OKAY, p);
    do_read(8'h10, 32'h1111_1111, OKAY, 0);
    do_read(8'h14, 32'h2222_2222, OKAY, 0);

    // read-only / unmapped accesses
    do_write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, SLVERR, p);
    chk("pulse_slverr", p, 16'h0000);
    do_read(8'h48, 32'h0, SLVERR, 0);
    do_read(8'h40, 32'd7, OKAY, 0);

    // stalled response channels
    do_write(8'h18, 32'h6666_6666, 4'hF, 0, 5, OKAY, p);
    do_read(8'h18, 32'h6666_6666, OKAY, 5);

    // all-zero strobe still counts as a write
    do_write(8'h1C, 32'hFFFF_FFFF, 4'h0, 0, 0, OKAY, p);
    chk("pulse_reg7", p, 16'h0080);

    // read coinciding with a commit returns the pre-write value
    fork
      do_write(8'h0C, 32'h5, 4'hF, 0, 0, OKAY, p);
      do_read(8'h0C, 32'h4, OKAY, 0);
    join
    fork
      do_write(8'h08, 32'h9, 4'hF, 0, 0, OKAY, p2);
      do_read(8'h40, 32'd10, OKAY, 0);
    join
    do_read(8'h40, 32'd11, OKAY, 0);
    do_read(8'h0C, 32'h5, OKAY, 0);
    do_read(8'h08, 32'h9, OKAY, 0);
    do_read(8'h1C, 32'h0, OKAY, 0);

    // reset between AW and W discards the half-written transaction
    @(posedge clk); #1;
    awaddr = 8'h20; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset_awready", awready, 1'b0);
    chk("midreset_wready", wready, 1'b0);
    chk("midreset_regs", reg_out, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_awready", awready, 1'b1);
    chk("rel_wready", wready, 1'b1);
    chk("rel_arready", arready, 1'b1);
    chk("rel_bvalid", bvalid, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("rel_no_bvalid", bvalid, 1'b0);
    do_read(8'h00, 32'h0, OKAY, 0);
    do_read(8'h40, 32'h0, OKAY, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
